// File: rtl/alu_rf_sequencer_if.sv
// Instruction handshake plus register-file access bundle for the ALU sequencer.
// master = sequencer side, slave = instruction source / register-file side.
interface alu_rf_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             instr_valid;
  logic             instr_ready;
  logic [1:0]       instr_op;
  logic [AW-1:0]    instr_rs1;
  logic [AW-1:0]    instr_rs2;
  logic [AW-1:0]    instr_rd;
  logic             instr_use_imm;
  logic [WIDTH-1:0] instr_imm;

  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] d_out_a;
  logic [WIDTH-1:0] d_out_b;
  logic             wr;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] d_in;
  logic             carry;
  logic             done;

  modport master (
    input  instr_valid, instr_op, instr_rs1, instr_rs2, instr_rd,
           instr_use_imm, instr_imm, d_out_a, d_out_b,
    output instr_ready, rd_addr_a, rd_addr_b, wr, wr_addr, d_in, carry, done
  );

  modport slave (
    output instr_valid, instr_op, instr_rs1, instr_rs2, instr_rd,
           instr_use_imm, instr_imm, d_out_a, d_out_b,
    input  instr_ready, rd_addr_a, rd_addr_b, wr, wr_addr, d_in, carry, done
  );
endinterface

// File: rtl/alu_rf_sequencer.sv
// Initiator-side sequencer for an 8x16 register file: accepts one ALU
// instruction, reads both operands, computes add/sub/and/or, writes back.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for an instruction; read addresses loaded on accept
// S_READ  | read addresses stable; operands captured at closing edge
// S_EXEC  | ALU result and carry-out registered at closing edge
// S_WRITE | wr/done asserted; register file and carry commit at edge
module alu_rf_sequencer #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic               clk,
  input  logic               reset,
  alu_rf_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

  state_t           state_q, state_d;

  logic [1:0]       op_q;
  logic [AW-1:0]    rd_q;
  logic             use_imm_q;
  logic [WIDTH-1:0] imm_q;
  logic [AW-1:0]    rd_addr_a_q, rd_addr_b_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [WIDTH-1:0] d_in_q;
  logic [AW-1:0]    wr_addr_q;
  logic             cout_q;
  logic             carry_q;

  logic             ready_c, wr_c, done_c;
  logic             accept;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_cout_c;

  assign accept = (state_q == S_IDLE) && bus.instr_valid;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: fixed four-cycle walk once an instruction is taken
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.instr_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ready_c = 1'b0;
    wr_c    = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      S_IDLE:  ready_c = 1'b1;
      S_WRITE: begin
        wr_c   = 1'b1;
        done_c = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU on the captured operands; sub uses A + ~B + 1 so carry=1 means no borrow
  always_comb begin
    sum_c      = '0;
    alu_res_c  = '0;
    alu_cout_c = 1'b0;
    unique case (op_q)
      2'b00: begin
        sum_c      = {1'b0, opa_q} + {1'b0, opb_q};
        alu_res_c  = sum_c[WIDTH-1:0];
        alu_cout_c = sum_c[WIDTH];
      end
      2'b01: begin
        sum_c      = {1'b0, opa_q} + {1'b0, ~opb_q} + (WIDTH+1)'(1);
        alu_res_c  = sum_c[WIDTH-1:0];
        alu_cout_c = sum_c[WIDTH];
      end
      2'b10:   alu_res_c = opa_q & opb_q;
      default: alu_res_c = opa_q | opb_q;
    endcase
  end

  // Instruction latch and registered read addresses, loaded on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= '0;
      rd_q        <= '0;
      use_imm_q   <= 1'b0;
      imm_q       <= '0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
    end else if (accept) begin
      op_q        <= bus.instr_op;
      rd_q        <= bus.instr_rd;
      use_imm_q   <= bus.instr_use_imm;
      imm_q       <= bus.instr_imm;
      rd_addr_a_q <= bus.instr_rs1;
      rd_addr_b_q <= bus.instr_rs2;
    end
  end

  // Operand capture at the end of READ; result/carry-out at the end of EXEC.
  // d_in and wr_addr only load here so they hold outside WRITE.
  always_ff @(posedge clk) begin
    if (reset) begin
      opa_q     <= '0;
      opb_q     <= '0;
      d_in_q    <= '0;
      wr_addr_q <= '0;
      cout_q    <= 1'b0;
    end else begin
      if (state_q == S_READ) begin
        opa_q <= bus.d_out_a;
        opb_q <= use_imm_q ? imm_q : bus.d_out_b;
      end
      if (state_q == S_EXEC) begin
        d_in_q    <= alu_res_c;
        wr_addr_q <= rd_q;
        cout_q    <= alu_cout_c;
      end
    end
  end

  // Architectural carry flag commits with the register-file write
  always_ff @(posedge clk) begin
    if (reset)                   carry_q <= 1'b0;
    else if (state_q == S_WRITE) carry_q <= cout_q;
  end

  assign bus.instr_ready = ready_c;
  assign bus.wr          = wr_c;
  assign bus.done        = done_c;
  assign bus.rd_addr_a   = rd_addr_a_q;
  assign bus.rd_addr_b   = rd_addr_b_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.d_in        = d_in_q;
  assign bus.carry       = carry_q;

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Directed bench for alu_rf_sequencer with a behavioural 8x16 register file.
module tb_alu_rf_sequencer;
  localparam int WIDTH = 16;
  localparam int AW    = 3;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  alu_rf_sequencer_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  alu_rf_sequencer #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Register file model: combinational reads, registered write, sync reset
  logic [WIDTH-1:0] rf [8];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (bus.wr) begin
      rf[bus.wr_addr] <= bus.d_in;
    end
  end
  assign bus.d_out_a = rf[bus.rd_addr_a];
  assign bus.d_out_b = rf[bus.rd_addr_b];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_instr(input logic [1:0] op, input logic [AW-1:0] rs1,
                             input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                             input logic use_imm, input logic [WIDTH-1:0] imm);
    bus.instr_op      = op;
    bus.instr_rs1     = rs1;
    bus.instr_rs2     = rs2;
    bus.instr_rd      = rd;
    bus.instr_use_imm = use_imm;
    bus.instr_imm     = imm;
  endtask

  // Issue one instruction and check each cycle of its occupancy inline
  task automatic do_instr(input string name, input logic [1:0] op,
                          input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic [AW-1:0] rd, input logic use_imm,
                          input logic [WIDTH-1:0] imm,
                          input logic [WIDTH-1:0] exp_d, input logic exp_c);
    int guard;
    @(negedge clk);
    drive_instr(op, rs1, rs2, rd, use_imm, imm);
    bus.instr_valid = 1'b1;
    guard = 0;
    while (bus.instr_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (guard >= 20) begin
      n_fail++;
      $display("FAIL %s accept timeout: instr_ready=%b required 1", name, bus.instr_ready);
    end
    @(negedge clk);  // READ
    bus.instr_valid = 1'b0;
    n_checks++;
    if (bus.instr_ready !== 1'b0 || bus.wr !== 1'b0 || bus.rd_addr_a !== rs1 || bus.rd_addr_b !== rs2) begin
      n_fail++;
      $display("FAIL %s read cycle: ready=%b wr=%b ra=%0d rb=%0d required ready=0 wr=0 ra=%0d rb=%0d",
               name, bus.instr_ready, bus.wr, bus.rd_addr_a, bus.rd_addr_b, rs1, rs2);
    end
    @(negedge clk);  // EXEC
    n_checks++;
    if (bus.instr_ready !== 1'b0 || bus.wr !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s exec cycle: ready=%b wr=%b done=%b required 0 0 0",
               name, bus.instr_ready, bus.wr, bus.done);
    end
    @(negedge clk);  // WRITE
    n_checks++;
    if (bus.wr !== 1'b1 || bus.done !== 1'b1 || bus.instr_ready !== 1'b0 ||
        bus.wr_addr !== rd || bus.d_in !== exp_d) begin
      n_fail++;
      $display("FAIL %s write cycle: wr=%b done=%b ready=%b wr_addr=%0d d_in=%h required 1 1 0 %0d %h",
               name, bus.wr, bus.done, bus.instr_ready, bus.wr_addr, bus.d_in, rd, exp_d);
    end
    @(negedge clk);  // back in IDLE
    n_checks++;
    if (bus.wr !== 1'b0 || bus.done !== 1'b0 || bus.instr_ready !== 1'b1 || bus.carry !== exp_c) begin
      n_fail++;
      $display("FAIL %s after write: wr=%b done=%b ready=%b carry=%b required 0 0 1 %b",
               name, bus.wr, bus.done, bus.instr_ready, bus.carry, exp_c);
    end
  endtask

  task automatic test_reset();
    bit saw_wr;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.instr_ready !== 1'b1 || bus.wr !== 1'b0 || bus.done !== 1'b0 || bus.carry !== 1'b0 ||
        bus.rd_addr_a !== '0 || bus.rd_addr_b !== '0) begin
      n_fail++;
      $display("FAIL reset state: ready=%b wr=%b done=%b carry=%b ra=%0d rb=%0d required 1 0 0 0 0 0",
               bus.instr_ready, bus.wr, bus.done, bus.carry, bus.rd_addr_a, bus.rd_addr_b);
    end
    reset = 1'b0;
    saw_wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.wr !== 1'b0 || bus.done !== 1'b0 || bus.instr_ready !== 1'b1) saw_wr = 1'b1;
    end
    n_checks++;
    if (saw_wr) begin
      n_fail++;
      $display("FAIL idle quiet: wr/done rose or ready dropped with instr_valid=0, required none");
    end
  endtask

  task automatic test_load_imm();
    do_instr("load_imm", 2'b00, 3'd0, 3'd0, 3'd1, 1'b1, 16'h1234, 16'h1234, 1'b0);
  endtask

  task automatic test_add_sub();
    do_instr("add_carry", 2'b00, 3'd1, 3'd0, 3'd2, 1'b1, 16'hEDCC, 16'h0000, 1'b1);
    do_instr("sub_borrow", 2'b01, 3'd2, 3'd1, 3'd3, 1'b0, 16'h0000, 16'hEDCC, 1'b0);
    do_instr("sub_noborrow", 2'b01, 3'd3, 3'd1, 3'd6, 1'b0, 16'h0000, 16'hDB98, 1'b1);
  endtask

  task automatic test_logic();
    do_instr("and_imm", 2'b10, 3'd1, 3'd0, 3'd7, 1'b1, 16'h00FF, 16'h0034, 1'b0);
    do_instr("or_imm",  2'b11, 3'd1, 3'd0, 3'd7, 1'b1, 16'h00FF, 16'h12FF, 1'b0);
    do_instr("or_reg_rd_eq_rs1", 2'b11, 3'd7, 3'd3, 3'd7, 1'b0, 16'h0000, 16'hFFFF, 1'b0);
  endtask

  task automatic test_back_to_back();
    int guard;
    @(negedge clk);
    drive_instr(2'b00, 3'd0, 3'd0, 3'd4, 1'b1, 16'h0005);
    bus.instr_valid = 1'b1;
    guard = 0;
    while (bus.instr_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);  // A in READ; present B with valid held
    drive_instr(2'b00, 3'd4, 3'd4, 3'd4, 1'b0, 16'h0000);
    @(negedge clk);  // A EXEC
    @(negedge clk);  // A WRITE
    n_checks++;
    if (bus.wr !== 1'b1 || bus.d_in !== 16'h0005 || bus.wr_addr !== 3'd4 || bus.instr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b A write: wr=%b d_in=%h wr_addr=%0d ready=%b required 1 0005 4 0",
               bus.wr, bus.d_in, bus.wr_addr, bus.instr_ready);
    end
    @(negedge clk);  // IDLE, B accepted at next edge
    n_checks++;
    if (bus.instr_ready !== 1'b1 || bus.wr !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b idle gap: ready=%b wr=%b required 1 0", bus.instr_ready, bus.wr);
    end
    @(negedge clk);  // B READ
    bus.instr_valid = 1'b0;
    n_checks++;
    if (bus.instr_ready !== 1'b0 || bus.rd_addr_a !== 3'd4 || bus.rd_addr_b !== 3'd4) begin
      n_fail++;
      $display("FAIL b2b B accept: ready=%b ra=%0d rb=%0d required 0 4 4",
               bus.instr_ready, bus.rd_addr_a, bus.rd_addr_b);
    end
    @(negedge clk);  // B EXEC
    @(negedge clk);  // B WRITE
    n_checks++;
    if (bus.wr !== 1'b1 || bus.done !== 1'b1 || bus.d_in !== 16'h000A || bus.wr_addr !== 3'd4) begin
      n_fail++;
      $display("FAIL b2b B write: wr=%b done=%b d_in=%h wr_addr=%0d required 1 1 000a 4",
               bus.wr, bus.done, bus.d_in, bus.wr_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    bit saw_pulse;
    int guard;
    @(negedge clk);
    drive_instr(2'b00, 3'd1, 3'd0, 3'd5, 1'b1, 16'h0001);
    bus.instr_valid = 1'b1;
    guard = 0;
    while (bus.instr_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);  // READ; a different instruction held on valid must be ignored
    drive_instr(2'b00, 3'd2, 3'd3, 3'd6, 1'b0, 16'h0000);
    @(negedge clk);  // EXEC
    n_checks++;
    if (bus.instr_ready !== 1'b0 || bus.rd_addr_a !== 3'd1) begin
      n_fail++;
      $display("FAIL busy ignores valid: ready=%b ra=%0d required 0 1", bus.instr_ready, bus.rd_addr_a);
    end
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (bus.wr !== 1'b0 || bus.done !== 1'b0 || bus.instr_ready !== 1'b1 || bus.carry !== 1'b0) begin
      n_fail++;
      $display("FAIL abort state: wr=%b done=%b ready=%b carry=%b required 0 0 1 0",
               bus.wr, bus.done, bus.instr_ready, bus.carry);
    end
    saw_pulse = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.wr !== 1'b0 || bus.done !== 1'b0 || bus.instr_ready !== 1'b1) saw_pulse = 1'b1;
    end
    n_checks++;
    if (saw_pulse) begin
      n_fail++;
      $display("FAIL aborted instr: wr/done pulse or ready drop after reset, required none");
    end
    // Register file was cleared with the abort; r5 must read back as zero
    do_instr("post_abort_read_r5", 2'b11, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0000, 16'h0000, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.instr_valid = 1'b0;
    drive_instr(2'b00, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);

    test_reset();
    test_load_imm();
    test_add_sub();
    test_logic();
    test_back_to_back();
    test_reset_mid_op();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_rf_sequencer.md
Name: alu_rf_sequencer

Overview:
- Initiator-side controller for the 8x16 register file (2 combinational read ports, 1 registered write port).
- Accepts one ALU instruction per valid/ready handshake and drives the register-file read addresses.
- Captures both operands, computes add/sub/and/or with the same 2-bit op encoding as the datapath ALU, then writes the result back through the write port.
- Sits between an instruction source and the register file.

Parameters:
- WIDTH, 16: datapath width; must match the register-file word.
- AW, 3: register address width (8 registers).

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  block can accept an instruction (high only in IDLE)
- instr_op  in  2  00 add, 01 sub, 10 and, 11 or
- instr_rs1  in  AW  source A register
- instr_rs2  in  AW  source B register
- instr_rd  in  AW  destination register
- instr_use_imm  in  1  1: operand B = instr_imm instead of register rs2
- instr_imm  in  WIDTH  immediate operand
- rd_addr_a  out  AW  register-file read address A
- rd_addr_b  out  AW  register-file read address B
- d_out_a  in  WIDTH  register-file read data A (combinational from rd_addr_a)
- d_out_b  in  WIDTH  register-file read data B
- wr  out  1  register-file write enable
- wr_addr  out  AW  register-file write address
- d_in  out  WIDTH  register-file write data
- carry  out  1  carry flag from last completed instruction
- done  out  1  one-cycle pulse, coincident with wr

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All outputs go to 0, except instr_ready, which is 1 in IDLE.
  - Registered instruction fields and operands are cleared.
- States: IDLE -> READ -> EXEC -> WRITE -> IDLE. This gives a fixed 4-cycle occupancy and one instruction per 4 cycles.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready at an edge, latch op, rs1, rs2, rd, use_imm and imm, then go to READ.
  - instr_valid while not in IDLE is ignored; instr_ready=0.
- READ:
  - rd_addr_a=rs1, rd_addr_b=rs2, both registered outputs.
  - At the end of the cycle, capture opA=d_out_a and opB = use_imm ? imm : d_out_b. Go to EXEC.
- EXEC: compute the result into a register using WIDTH-bit modular arithmetic.
  - add: res=A+B; carry-out = bit WIDTH of the (WIDTH+1)-bit sum.
  - sub: res = A + ~B + 1; carry-out = 1 means no borrow (A>=B unsigned).
  - and: res = A&B; carry-out = 0.
  - or: res = A|B; carry-out = 0.
  - Go to WRITE.
- WRITE:
  - wr=1, wr_addr=rd, d_in=res, done=1 for exactly this cycle. The register file commits at the closing edge.
  - carry updates at that same edge.
  - Next state is IDLE.
- Outside WRITE: wr=0, done=0. wr_addr and d_in hold their last values (don't-care to the register file).
- Hazards:
  - The write commits before the next READ can occur, so back-to-back instructions with rd == rs1/rs2 read the new value. No forwarding is needed.
  - rd == rs1 within one instruction is legal; the old value is used as the operand.
- Reset mid-operation (READ/EXEC/WRITE): the instruction is aborted.
  - If reset is high in the WRITE cycle, wr is still driven but the register file resets at the same edge. The result is not committed and done is not counted.
  - The next cycle is IDLE.
- Reading register 0 is not special; it returns whatever was written there.

Test Plan:
- Reset: hold reset 2 cycles -> instr_ready=1, wr=0, done=0, carry=0, rd_addr_a/b=0; instr_valid=0 for 10 cycles -> wr never rises.
- Load immediate: op=00, rs1=0 (reset value 0), use_imm=1, imm=16'h1234, rd=1 accepted at edge N -> wr=1, wr_addr=1, d_in=16'h1234, done=1 in cycle N+3 only; carry=0; instr_ready low for cycles N+1..N+3.
- Add with carry: r1=16'h1234, op=00, rs1=1, imm=16'hEDCC, rd=2 -> d_in=16'h0000, carry=1. Follow with op=01, rs1=2, rs2=1, rd=3 (0-0x1234) -> d_in=16'hEDCC, carry=0 (borrow).
- Logic: rs1=1 (16'h1234), imm=16'h00FF. op=10 -> d_in=16'h0034, carry=0. op=11 -> d_in=16'h12FF, carry=0.
- Back-to-back RAW hazard: instr A writes r4=16'h0005; instr B presented with instr_valid held continuously, op=00, rs1=4, rs2=4, rd=4 -> B accepted the cycle after A's WRITE; d_in=16'h000A.
- Reset mid-op: assert reset during EXEC of an instruction targeting r5 -> no wr pulse, no done pulse, instr_ready=1 the cycle after reset deasserts; instruction held on instr_valid during the busy cycles is not accepted until IDLE.
